// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 32-bit memory port between the CPU data port
// (read/write, priority) and the instruction prefetch port (read-only).
// A starvation counter forces a prefetch grant after STARVE_LIMIT
// consecutive data grants made while a prefetch was waiting.
module mem_arbiter #(
  parameter int READ_LATENCY = 2,  // edges from o_address valid to i_data valid (1..7)
  parameter int STARVE_LIMIT = 4   // data grants tolerated while fetch waits (1..15)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        d_req,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  input  logic        f_req,
  input  logic [31:0] f_address,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        busy,
  output logic [31:0] o_address,
  output logic [31:0] o_data,
  output logic        o_we,
  input  logic [31:0] i_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

  state_t      state_reg, state_next;
  logic        owner_f_reg;   // 1 when the current transaction belongs to prefetch
  logic [2:0]  cnt_reg;       // remaining read latency edges
  logic [3:0]  starve_reg;    // data grants issued while fetch was pending

  logic        any_req;
  logic        grant_f;

  assign any_req = d_req | f_req;
  // Data wins unless fetch has waited through STARVE_LIMIT data grants.
  assign grant_f = f_req & (~d_req | (starve_reg == 4'(STARVE_LIMIT)));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; ACK always returns to IDLE so a held request is
  // only re-evaluated once the requester has seen its ack.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          if (!grant_f && d_we) state_next = WRITE;
          else                  state_next = READ;
        end
      end
      WRITE:   state_next = ACK;
      READ:    if (cnt_reg == 3'd0) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant capture, memory port registers, latency and starvation counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_f_reg <= 1'b0;
      cnt_reg     <= 3'd0;
      starve_reg  <= 4'd0;
      o_address   <= 32'd0;
      o_data      <= 32'd0;
      o_we        <= 1'b0;
      d_rdata     <= 32'd0;
      f_rdata     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_f_reg <= grant_f;
            cnt_reg     <= 3'(READ_LATENCY);
            if (grant_f) begin
              o_address  <= f_address;
              starve_reg <= 4'd0;
            end else begin
              o_address <= d_address;
              if (d_we) begin
                o_data <= d_wdata;
                o_we   <= 1'b1;
              end
              if (!f_req)
                starve_reg <= 4'd0;
              else if (starve_reg != 4'(STARVE_LIMIT))
                starve_reg <= starve_reg + 4'd1;
            end
          end else begin
            // Idle with no request implies no fetch is waiting.
            starve_reg <= 4'd0;
          end
        end
        WRITE: o_we <= 1'b0;
        READ: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else if (owner_f_reg) begin
            f_rdata <= i_data;
          end else begin
            d_rdata <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the single owner bit keeps acks exclusive.
  always_comb begin
    d_ack = (state_reg == ACK) & ~owner_f_reg;
    f_ack = (state_reg == ACK) &  owner_f_reg;
    busy  = (state_reg != IDLE);
  end

endmodule
